aes_sbox_sub_bytes: RTL and testbench

AES_SBOX_SUB_BYTES -- requirements
Module: aes_sbox_sub_bytes

---
 rtl/aes_sbox_sub_bytes.sv | 109 ++++++++++
 tb/tb_aes_sbox_sub_bytes.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_sub_bytes.sv
// Iterative AES SubBytes: latches a 128-bit state, substitutes BYTES_PER_CYCLE bytes
// per cycle in place, then presents the result until the downstream stage takes it.
//
// state | meaning
// IDLE  | waiting for a new state; in_ready=1
// BUSY  | substituting byte group cnt each cycle
// DONE  | result held on out_data; out_valid=1 until out_ready
module aes_sbox_sub_bytes #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q, work_sub;
  logic            last;

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte i lives at bits [127-8i -: 8]; only the group selected by cnt is replaced.
  always_comb begin
    work_sub = work_q;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CW'(g)) begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_sub[127-8*(g*BYTES_PER_CYCLE+j) -: 8] = SBOX[work_q[127-8*(g*BYTES_PER_CYCLE+j) -: 8]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      work_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= in_data;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          work_q <= work_sub;
          cnt_q  <= last ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_aes_sbox_sub_bytes.sv
// Directed and round-trip checks of aes_sbox_sub_bytes at every legal BYTES_PER_CYCLE;
// the reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_sbox_sub_bytes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [5];
  logic         out_ready [5];
  logic [127:0] in_data   [5];
  logic         in_ready  [5];
  logic         out_valid [5];
  logic [127:0] out_data  [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sbox_sub_bytes #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];
  bit seen_in  [256];
  bit seen_out [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[sb[x]] = 8'(x);
    end
  endtask

  // Offers d when in_ready, waits for out_valid, returns the result and latency, then drains.
  task automatic run_state(input int k, input logic [127:0] d,
                           output logic [127:0] res, output int lat);
    int w = 0;
    while (!in_ready[k] && w < 40) begin @(negedge clk); w++; end
    chk("accept_wait", 128'(w < 40), 128'(1));
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin @(negedge clk); lat++; end
    chk("done_wait", 128'(lat < 40), 128'(1));
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  localparam logic [127:0] R1_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] R1_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] ALL63  = 128'h63636363_63636363_63636363_63636363;

  initial begin
    logic [127:0] res, d;
    int lat, w, spur, n_in, n_out;

    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
    end
    build_model();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst_in_ready",  128'(in_ready[k]),  128'(1));
      chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
      chk("rst_out_data",  out_data[k],        128'(0));
    end
    rst = 1'b0;

    run_state(2, 128'(0), res, lat);
    chk("zero_lat", 128'(lat), 128'(4));
    chk("zero_data", res, ALL63);
    run_state(2, R1_IN, res, lat);
    chk("r1_data", res, R1_OUT);
    run_state(0, 128'h00010203_04050607_08090a0b_0c0d0e0f, res, lat);
    chk("bpc1_lat", 128'(lat), 128'(16));
    chk("bpc1_data", res, 128'h637c777b_f26b6fc5_3001672b_fed7ab76);
    run_state(3, 128'h5352ff01_00000000_00000000_00000000, res, lat);
    chk("spot_bpc8_lat", 128'(lat), 128'(2));
    chk("spot_bpc8", res, 128'hed00167c_63636363_63636363_63636363);
    run_state(4, 128'h5352ff01_00000000_00000000_00000000, res, lat);
    chk("spot_bpc16_lat", 128'(lat), 128'(1));
    chk("spot_bpc16", res, 128'hed00167c_63636363_63636363_63636363);

    // Backpressure in DONE with a competing input offered throughout.
    in_valid[2] = 1'b1; in_data[2] = R1_IN;
    @(negedge clk);
    in_valid[2] = 1'b0;
    w = 0;
    while (!out_valid[2] && w < 40) begin @(negedge clk); w++; end
    chk("bp_done_wait", 128'(w < 40), 128'(1));
    in_valid[2] = 1'b1; in_data[2] = 128'(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid[2]), 128'(1));
      chk("bp_out_data",  out_data[2],        R1_OUT);
      chk("bp_in_ready",  128'(in_ready[2]),  128'(0));
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;
    chk("bp_release_idle",  128'(in_ready[2]),  128'(1));
    chk("bp_release_valid", 128'(out_valid[2]), 128'(0));
    @(negedge clk);
    in_valid[2] = 1'b0;
    chk("bp_new_taken", 128'(in_ready[2]), 128'(0));
    w = 0;
    while (!out_valid[2] && w < 40) begin @(negedge clk); w++; end
    chk("bp_new_wait", 128'(w < 40), 128'(1));
    chk("bp_new_data", out_data[2], ALL63);
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;

    // Reset mid-BUSY at cnt=2, with in_valid offered during reset.
    in_valid[2] = 1'b1; in_data[2] = R1_IN;
    @(negedge clk);
    in_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; in_valid[2] = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid[2] = 1'b0;
    chk("mid_rst_in_ready",  128'(in_ready[2]),  128'(1));
    chk("mid_rst_out_valid", 128'(out_valid[2]), 128'(0));
    chk("mid_rst_out_data",  out_data[2],        128'(0));
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid[2]) spur++;
    end
    chk("mid_rst_no_spurious", 128'(spur), 128'(0));
    chk("mid_rst_still_idle",  128'(in_ready[2]), 128'(1));
    chk("mid_rst_data_zero",   out_data[2], 128'(0));

    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 1000; t++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        run_state(k, d, res, lat);
        chk("rt_lat", 128'(lat), 128'(16 >> k));
        chk("roundtrip", inv_state(res), d);
        for (int i = 0; i < 16; i++) begin
          seen_in[d[127-8*i -: 8]]    = 1'b1;
          seen_out[res[127-8*i -: 8]] = 1'b1;
        end
      end
    end
    n_in = 0; n_out = 0;
    for (int v = 0; v < 256; v++) begin
      if (seen_in[v])  n_in++;
      if (seen_out[v]) n_out++;
    end
    chk("cover_in",  128'(n_in),  128'(256));
    chk("cover_out", 128'(n_out), 128'(256));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
